// File: rtl/rr_arb32.sv
// -----------------------------------------------------------------------------
// rr_arb32 -- 32-requester round-robin arbiter with grant timeout
//
// Grants one requester at a time. In IDLE the highest-priority requester is
// marked by a rotating pointer; the first set request bit found scanning
// ptr, ptr+1, ... 31, 0, ... ptr-1 wins. The grant is held until the grantee
// acks (release) or until TIMEOUT consecutive GRANT cycles pass without ack
// (revocation, flagged with a one-cycle timeout pulse). Either way the
// pointer moves to the slot just after the grantee, and at least one IDLE
// cycle separates consecutive grants.
//
// Parameters
//   TIMEOUT  GRANT cycles without ack before revocation; 0 disables it.
//
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   req      in  32   request vector, bit i = requester i
//   ack      in   1   grantee accepts and releases the grant
//   lock     in   1   grantee keeps the grant (only with ARB_LOCK_EN)
//   gnt_idx  out  5   binary index of the granted requester
//   gnt_vld  out  1   gnt_idx holds a valid grant
//   timeout  out  1   one-cycle pulse when a grant is revoked
//
// Build options
//   ARB_LOCK_EN  when defined, adds the lock input. While lock=1 an ack does
//                not release (it clears the wait counter instead) and the
//                wait counter does not advance, so no timeout can fire.
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module rr_arb32 #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic        ack,
`ifdef ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic [4:0]  gnt_idx,
    output logic        gnt_vld,
    output logic        timeout
);

    // Counter wide enough to hold TIMEOUT-1; never narrower than one bit.
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit TO_EN = (TIMEOUT > 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg;
    logic [4:0]      ptr_reg;
    logic [CW-1:0]   cnt_reg;
    logic [4:0]      gnt_idx_reg;
    logic            gnt_vld_reg;
    logic            timeout_reg;

    // -------------------------------------------------------------------------
    // Lock qualifier: a constant 0 in the default build so the lock branches
    // of the FSM fold away.
    // -------------------------------------------------------------------------
    logic lock_s;
`ifdef ARB_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Rotate the request vector so that bit 0 of req_rot corresponds to the
    // requester at ptr. Indexing the doubled vector avoids a modulo: entry
    // ptr+gi of {req,req} is req[(ptr+gi) mod 32].
    // -------------------------------------------------------------------------
    logic [63:0] req_dbl;
    logic [31:0] req_rot;

    assign req_dbl = {req, req};

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rot
            assign req_rot[gi] = req_dbl[{1'b0, ptr_reg} + 6'(gi)];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Lowest set bit of the rotated vector: a prefix-OR marks every position
    // at or above the first set bit; the winner is the single position where
    // the prefix first goes high.
    // -------------------------------------------------------------------------
    logic [31:0] seen;
    logic [31:0] first_hot;

    assign seen[0]      = req_rot[0];
    assign first_hot[0] = req_rot[0];

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_prio
            assign seen[gi]      = seen[gi-1] | req_rot[gi];
            assign first_hot[gi] = req_rot[gi] & ~seen[gi-1];
        end
    endgenerate

    // One-hot to binary offset from ptr.
    logic [4:0] pick_off;

    always_comb begin
        pick_off = '0;
        for (int i = 0; i < 32; i++) begin
            if (first_hot[i]) begin
                pick_off = pick_off | 5'(i);
            end
        end
    end

    // Absolute index of the winner; 5-bit addition wraps naturally at 32.
    logic [4:0] pick_idx;
    assign pick_idx = ptr_reg + pick_off;

    // Slot following the current grantee, used by both release and revoke.
    logic [4:0] next_ptr;
    assign next_ptr = gnt_idx_reg + 5'd1;

    // The current GRANT cycle is the TIMEOUT-th one without ack.
    logic to_fire;
    assign to_fire = TO_EN && (cnt_reg == CNT_LAST);

    // -------------------------------------------------------------------------
    // State machine with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            gnt_idx_reg <= '0;
            gnt_vld_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // ack is meaningless here; a stale gnt_idx is kept on
                    // purpose so the downstream decoder input stays quiet.
                    timeout_reg <= 1'b0;
                    if (|req) begin
                        gnt_idx_reg <= pick_idx;
                        gnt_vld_reg <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= GRANT;
                    end
                end

                GRANT: begin
                    timeout_reg <= 1'b0;
                    if (lock_s) begin
                        // Grant is pinned; an ack only restarts the wait.
                        if (ack) begin
                            cnt_reg <= '0;
                        end
                    end else if (ack) begin
                        // ack is checked before the timeout so that an ack
                        // landing on the final cycle is a normal release.
                        gnt_vld_reg <= 1'b0;
                        ptr_reg     <= next_ptr;
                        state_reg   <= IDLE;
                    end else if (to_fire) begin
                        gnt_vld_reg <= 1'b0;
                        timeout_reg <= 1'b1;
                        ptr_reg     <= next_ptr;
                        state_reg   <= IDLE;
                    end else if (TO_EN) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    gnt_vld_reg <= 1'b0;
                    timeout_reg <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_idx = gnt_idx_reg;
    assign gnt_vld = gnt_vld_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_arb32.sv
// -----------------------------------------------------------------------------
// tb_rr_arb32 -- self-checking bench for rr_arb32 (TIMEOUT = 3)
//
// The driver applies one input vector per clock at the falling edge, advances
// a behavioural model of the arbiter and queues the outputs expected after the
// next rising edge. A separate monitor pops one expectation per rising edge
// and compares it with the DUT. Resets are applied asynchronously in the
// middle of the low clock phase and checked directly.
// -----------------------------------------------------------------------------
module tb_rr_arb32;

    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] req = '0;
    logic        ack = 1'b0;
    logic        lock = 1'b0;
    logic [4:0]  gnt_idx;
    logic        gnt_vld;
    logic        timeout;

    always #5 clk = ~clk;

    rr_arb32 #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    typedef struct packed {
        logic       vld;
        logic [4:0] idx;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_grants = 0;

    // Behavioural model state.
    bit m_gnt;
    int m_idx;
    int m_ptr;
    int m_wait;
    bit m_to;

    function automatic void model_reset();
        m_gnt  = 0;
        m_idx  = 0;
        m_ptr  = 0;
        m_wait = 0;
        m_to   = 0;
    endfunction

    // One clock edge of the arbiter, as the rules describe it.
    function automatic void model_step(input logic [31:0] r, input logic a, input logic l);
        bit found;
        m_to = 0;
        if (!m_gnt) begin
            found = 0;
            for (int k = 0; k < 32; k++) begin
                int j;
                j = (m_ptr + k) % 32;
                if (!found && r[j]) begin
                    m_idx = j;
                    found = 1;
                end
            end
            if (found) begin
                m_gnt  = 1;
                m_wait = 0;
            end
        end else if (l) begin
            if (a) m_wait = 0;
        end else if (a) begin
            m_gnt = 0;
            m_ptr = (m_idx + 1) % 32;
        end else begin
            m_wait = m_wait + 1;
            if (TO > 0 && m_wait == TO) begin
                m_gnt = 0;
                m_to  = 1;
                m_ptr = (m_idx + 1) % 32;
            end
        end
    endfunction

    // Drive one vector (called at a falling edge), queue the expectation and
    // move to the next falling edge.
    task automatic cycle(input logic [31:0] r, input logic a, input logic l);
        exp_t e;
        req  = r;
        ack  = a;
        lock = l;
        model_step(r, a, l);
        e.vld = m_gnt;
        e.idx = 5'(m_idx);
        e.to  = m_to;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse, entered and left at a falling edge.
    task automatic do_reset();
        req  = '0;
        ack  = 1'b0;
        lock = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({gnt_vld, gnt_idx, timeout} !== 7'b0) begin
            n_bad++;
            $display("FAIL async_reset: got vld=%0b idx=%0d to=%0b, want vld=0 idx=0 to=0",
                     gnt_vld, gnt_idx, timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: one expectation per rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({gnt_vld, gnt_idx, timeout} !== {e.vld, e.idx, e.to}) begin
                n_bad++;
                $display("FAIL outputs @%0t: got vld=%0b idx=%0d to=%0b, want vld=%0b idx=%0d to=%0b",
                         $time, gnt_vld, gnt_idx, timeout, e.vld, e.idx, e.to);
            end else if (e.vld && n_grants < 100000) begin
                n_grants++;
                $display("grant  @%0t idx=%0d", $time, e.idx);
            end else if (e.to) begin
                $display("revoke @%0t idx=%0d", $time, e.idx);
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic        a;
        logic        l;

        model_reset();
        @(negedge clk);
        do_reset();

        // Single requester, then search resumes at 1.
        repeat (4) cycle(32'h0000_0001, m_gnt, 1'b0);
        repeat (4) cycle(32'h0000_0003, m_gnt, 1'b0);

        // Wrap-around between 31 and 0.
        do_reset();
        repeat (8) cycle(32'h8000_0001, m_gnt, 1'b0);

        // Full fairness sweep over all 32 indices.
        do_reset();
        repeat (68) cycle(32'hFFFF_FFFF, m_gnt, 1'b0);

        // Timeout with no ack, then ack colliding with the final cycle.
        do_reset();
        repeat (10) cycle(32'h0000_0010, 1'b0, 1'b0);
        repeat (12) cycle(32'h0000_0010, m_gnt && (m_wait == TO - 1), 1'b0);

        // Reset in the middle of a grant.
        cycle(32'h0000_0040, 1'b0, 1'b0);
        cycle(32'h0000_0040, 1'b0, 1'b0);
        do_reset();
        repeat (3) cycle(32'h0000_0040, m_gnt, 1'b0);

`ifdef ARB_LOCK_EN
        // Locked grant ignores ack and never times out.
        do_reset();
        cycle(32'h0000_0004, 1'b0, 1'b0);
        repeat (10) cycle(32'h0000_0004, 1'b1, 1'b1);
        cycle(32'h0000_0004, 1'b1, 1'b0);
        repeat (4) cycle(32'h0000_000C, m_gnt, 1'b0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       r = $urandom;
                1:       r = 32'h1 << $urandom_range(0, 31);
                2:       r = $urandom & $urandom & $urandom;
                default: r = '0;
            endcase
            a = ($urandom_range(0, 3) == 0);
`ifdef ARB_LOCK_EN
            l = ($urandom_range(0, 4) == 0);
`else
            l = 1'b0;
`endif
            cycle(r, a, l);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        cycle(32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
